// File: rtl/stage_exe_md.sv
// MIPS-style execute stage: ALU, branch-target adder and EX/MEM register, with an
// iterative multiply/divide unit (HI/LO) that runs alongside independent instructions.
module stage_exe_md #(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int SHW = $clog2(DW)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          flush,
    input  logic          stall_in,
    output logic          stall_out,
    input  logic [DW-1:0] data_a,
    input  logic [DW-1:0] data_b,
    input  logic [DW-1:0] data_imm,
    input  logic [DW-1:0] npc,
    input  logic [4:0]    alu_op,
    input  logic          use_imm,
    input  logic          reg_dst,
    input  logic [RW-1:0] regaddr1,
    input  logic [RW-1:0] regaddr2,
    input  logic          is_jump,
    input  logic          branch_eq,
    input  logic          branch_ne,
    input  logic [1:0]    wbi,
    input  logic          mem_ctl,
    output logic          out_valid,
    output logic [DW-1:0] out,
    output logic          zero,
    output logic [DW-1:0] jump_address,
    output logic          is_jump_o,
    output logic          branch_eq_o,
    output logic          branch_ne_o,
    output logic [1:0]    wbi_o,
    output logic          M_o,
    output logic [RW-1:0] regaddr_o,
    output logic [DW-1:0] data_b_o,
    output logic          md_busy
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_NOR   = 5'd5,
        OP_SLT   = 5'd6,
        OP_SLTU  = 5'd7,
        OP_SLL   = 5'd8,
        OP_SRL   = 5'd9,
        OP_SRA   = 5'd10,
        OP_MULT  = 5'd16,
        OP_MULTU = 5'd17,
        OP_DIV   = 5'd18,
        OP_DIVU  = 5'd19,
        OP_MFHI  = 5'd20,
        OP_MFLO  = 5'd21
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } md_state_e;

    alu_op_e         op;
    md_state_e       state, state_next;
    logic [CW-1:0]   count;
    logic [DW-1:0]   acc_hi, acc_lo, operand_y, dividend_orig;
    logic            md_is_div, neg_q, neg_r, div_by_zero;
    logic [DW-1:0]   hi, lo;

    logic [DW-1:0]   operand_b, alu_result;
    logic [SHW-1:0]  shamt;
    logic            is_md_start_op, is_md_op, accept, md_start;
    logic            signed_op, a_neg, b_neg;
    logic [DW-1:0]   abs_a, abs_b;
    logic [DW:0]     mul_sum, div_shift;
    logic [DW+1:0]   div_diff;
    logic [2*DW-1:0] product, product_fixed;

    assign op             = alu_op_e'(alu_op);
    assign operand_b      = use_imm ? data_imm : data_b;
    assign shamt          = operand_b[SHW-1:0];
    assign is_md_start_op = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    assign is_md_op       = is_md_start_op || op == OP_MFHI || op == OP_MFLO;
    assign md_busy        = (state != S_IDLE);
    assign stall_out      = stall_in | (md_busy & is_md_op);
    assign accept         = in_valid & ~stall_out & ~flush;
    assign md_start       = accept & is_md_start_op;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        alu_result = '0;
        case (op)
            OP_ADD:  alu_result = data_a + operand_b;
            OP_SUB:  alu_result = data_a - operand_b;
            OP_AND:  alu_result = data_a & operand_b;
            OP_OR:   alu_result = data_a | operand_b;
            OP_XOR:  alu_result = data_a ^ operand_b;
            OP_NOR:  alu_result = ~(data_a | operand_b);
            OP_SLT:  alu_result = {{(DW-1){1'b0}}, $signed(data_a) < $signed(operand_b)};
            OP_SLTU: alu_result = {{(DW-1){1'b0}}, data_a < operand_b};
            OP_SLL:  alu_result = data_a << shamt;
            OP_SRL:  alu_result = data_a >> shamt;
            OP_SRA:  alu_result = $signed(data_a) >>> shamt;
            OP_MFHI: alu_result = hi;
            OP_MFLO: alu_result = lo;
            default: alu_result = '0;
        endcase
    end

    // Signed forms iterate on magnitudes; the signs are re-applied in DONE.
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = signed_op & data_a[DW-1];
    assign b_neg     = signed_op & data_b[DW-1];
    assign abs_a     = a_neg ? -data_a : data_a;
    assign abs_b     = b_neg ? -data_b : data_b;

    // acc_hi/acc_lo hold the partial product, or remainder/quotient while dividing.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_y} : {(DW+1){1'b0}});
    assign div_shift = {acc_hi, acc_lo[DW-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, operand_y};

    assign product       = {acc_hi, acc_lo};
    assign product_fixed = neg_q ? -product : product;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (md_start) state_next = S_RUN;
            S_RUN:   if (count == CW'(1)) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: the iteration registers are reset too, so an aborted operation leaves nothing behind.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count         <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            operand_y     <= '0;
            dividend_orig <= '0;
            md_is_div     <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            div_by_zero   <= 1'b0;
            hi            <= '0;
            lo            <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (md_start) begin
                        count         <= CW'(DW);
                        md_is_div     <= alu_op[1];
                        neg_q         <= a_neg ^ b_neg;
                        neg_r         <= a_neg;
                        div_by_zero   <= (data_b == '0);
                        dividend_orig <= data_a;
                        operand_y     <= abs_b;
                        acc_hi        <= '0;
                        acc_lo        <= abs_a;
                    end
                end
                S_RUN: begin
                    count <= count - CW'(1);
                    if (md_is_div) begin
                        if (!div_diff[DW+1]) begin
                            acc_hi <= div_diff[DW-1:0];
                            acc_lo <= {acc_lo[DW-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[DW-1:0];
                            acc_lo <= {acc_lo[DW-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[DW-1:1]};
                    end
                end
                S_DONE: begin
                    if (!md_is_div) begin
                        {hi, lo} <= product_fixed;
                    end else if (div_by_zero) begin
                        lo <= '1;
                        hi <= dividend_orig;
                    end else begin
                        lo <= neg_q ? -acc_lo : acc_lo;
                        hi <= neg_r ? -acc_hi : acc_hi;
                    end
                end
                default: ;
            endcase
        end
    end

    // EX/MEM register: MULT/DIV and flushed or stalled-out slots load as bubbles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out          <= '0;
            zero         <= 1'b0;
            jump_address <= '0;
            is_jump_o    <= 1'b0;
            branch_eq_o  <= 1'b0;
            branch_ne_o  <= 1'b0;
            wbi_o        <= '0;
            M_o          <= 1'b0;
            regaddr_o    <= '0;
            data_b_o     <= '0;
        end else if (!stall_in) begin
            out_valid    <= accept & ~is_md_start_op;
            out          <= alu_result;
            zero         <= (alu_result == '0);
            jump_address <= npc + data_imm;
            is_jump_o    <= is_jump;
            branch_eq_o  <= branch_eq;
            branch_ne_o  <= branch_ne;
            wbi_o        <= wbi;
            M_o          <= mem_ctl;
            regaddr_o    <= reg_dst ? regaddr1 : regaddr2;
            data_b_o     <= data_b;
        end
    end

endmodule

// File: tb/tb_stage_exe_md.sv
// Self-checking bench for stage_exe_md: scoreboard on the EX/MEM output plus
// directed checks of stalls, flushes, reset and the mult/div timing.
`timescale 1ns/1ps
module tb_stage_exe_md;
    localparam int DW   = 32;
    localparam int RW   = 5;
    localparam int DW16 = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic          in_valid, flush, stall_in, stall_out;
    logic [DW-1:0] data_a, data_b, data_imm, npc;
    logic [4:0]    alu_op;
    logic          use_imm, reg_dst;
    logic [RW-1:0] regaddr1, regaddr2;
    logic          is_jump, branch_eq, branch_ne, mem_ctl;
    logic [1:0]    wbi;
    logic          out_valid, zero, is_jump_o, branch_eq_o, branch_ne_o, M_o, md_busy;
    logic [DW-1:0] out, jump_address, data_b_o;
    logic [1:0]    wbi_o;
    logic [RW-1:0] regaddr_o;

    stage_exe_md #(.DW(DW), .RW(RW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .flush(flush),
        .stall_in(stall_in), .stall_out(stall_out), .data_a(data_a), .data_b(data_b),
        .data_imm(data_imm), .npc(npc), .alu_op(alu_op), .use_imm(use_imm),
        .reg_dst(reg_dst), .regaddr1(regaddr1), .regaddr2(regaddr2), .is_jump(is_jump),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .wbi(wbi), .mem_ctl(mem_ctl),
        .out_valid(out_valid), .out(out), .zero(zero), .jump_address(jump_address),
        .is_jump_o(is_jump_o), .branch_eq_o(branch_eq_o), .branch_ne_o(branch_ne_o),
        .wbi_o(wbi_o), .M_o(M_o), .regaddr_o(regaddr_o), .data_b_o(data_b_o),
        .md_busy(md_busy)
    );

    logic            v16, st16;
    logic [DW16-1:0] a16, b16, o16, ja16, db16;
    logic [4:0]      op16;
    logic            ov16, z16, ij16, be16, bn16, m16, busy16;
    logic [1:0]      wbi16;
    logic [RW-1:0]   ra16;

    stage_exe_md #(.DW(DW16), .RW(RW)) dut16 (
        .clock(clock), .reset(reset), .in_valid(v16), .flush(1'b0),
        .stall_in(1'b0), .stall_out(st16), .data_a(a16), .data_b(b16),
        .data_imm(16'h0), .npc(16'h0), .alu_op(op16), .use_imm(1'b0),
        .reg_dst(1'b0), .regaddr1(5'h0), .regaddr2(5'h0), .is_jump(1'b0),
        .branch_eq(1'b0), .branch_ne(1'b0), .wbi(2'b00), .mem_ctl(1'b0),
        .out_valid(ov16), .out(o16), .zero(z16), .jump_address(ja16),
        .is_jump_o(ij16), .branch_eq_o(be16), .branch_ne_o(bn16),
        .wbi_o(wbi16), .M_o(m16), .regaddr_o(ra16), .data_b_o(db16),
        .md_busy(busy16)
    );

    typedef struct {
        logic [DW-1:0] out;
        logic          zero;
        logic [DW-1:0] jaddr;
        logic [RW-1:0] rd;
        logic [5:0]    ctl;
        logic [DW-1:0] db;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic ld = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // ld marks that the output register loaded at the last edge.
    always @(posedge clock or posedge reset) begin
        if (reset) ld <= 1'b0;
        else       ld <= !stall_in;
    end

    always @(negedge clock) begin
        if (!reset && ld && out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected out=%h required=no output", out);
            end else begin
                mon_e = sb.pop_front();
                if (out !== mon_e.out || zero !== mon_e.zero || jump_address !== mon_e.jaddr ||
                    regaddr_o !== mon_e.rd || data_b_o !== mon_e.db ||
                    {is_jump_o, branch_eq_o, branch_ne_o, wbi_o, M_o} !== mon_e.ctl) begin
                    errors++;
                    $display("FAIL sb_compare out=%h/%h zero=%b/%b jaddr=%h/%h rd=%h/%h ctl=%b/%b db=%h/%h (actual/required)",
                             out, mon_e.out, zero, mon_e.zero, jump_address, mon_e.jaddr,
                             regaddr_o, mon_e.rd, {is_jump_o, branch_eq_o, branch_ne_o, wbi_o, M_o},
                             mon_e.ctl, data_b_o, mon_e.db);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return ~(a | b);
            5'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd7:    return (a < b) ? 32'd1 : 32'd0;
            5'd8:    return a << s;
            5'd9:    return a >> s;
            5'd10:   return 32'($signed(a) >>> s);
            default: return 32'd0;
        endcase
    endfunction

    task automatic md_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sbv;
        logic [63:0] p, q, r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        p = '0;
        case (op)
            5'd16: p = sa * sbv;
            5'd17: p = {32'h0, a} * {32'h0, b};
            5'd18: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else begin q = sa / sbv; r = sa % sbv; p = {r[31:0], q[31:0]}; end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else begin q = {32'h0, a / b}; r = {32'h0, a % b}; p = {r[31:0], q[31:0]}; end
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endtask

    task automatic drive_fields(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [DW-1:0] imm, input logic ui, output exp_t e);
        alu_op    = op;
        data_a    = a;
        data_b    = b;
        data_imm  = imm;
        use_imm   = ui;
        npc       = $urandom;
        reg_dst   = 1'($urandom_range(0, 1));
        regaddr1  = 5'($urandom);
        regaddr2  = 5'($urandom);
        is_jump   = 1'($urandom_range(0, 1));
        branch_eq = 1'($urandom_range(0, 1));
        branch_ne = 1'($urandom_range(0, 1));
        wbi       = 2'($urandom);
        mem_ctl   = 1'($urandom_range(0, 1));
        in_valid  = 1'b1;
        flush     = 1'b0;
        e.out   = '0;
        e.zero  = 1'b1;
        e.jaddr = npc + imm;
        e.rd    = reg_dst ? regaddr1 : regaddr2;
        e.ctl   = {is_jump, branch_eq, branch_ne, wbi, mem_ctl};
        e.db    = b;
    endtask

    // Presents one instruction, waits for acceptance, returns the accepting edge number.
    task automatic send(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] imm, input logic ui, input bit expect_out,
                        input logic [DW-1:0] exp_out, output int acc);
        exp_t e;
        int   n;
        drive_fields(op, a, b, imm, ui, e);
        if (expect_out) begin
            e.out  = exp_out;
            e.zero = (exp_out == '0);
            sb.push_back(e);
        end
        #1;
        n = 0;
        while (stall_out !== 1'b0 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout op=%0d stall_out=%b required=0", op, stall_out);
        end
        acc = cyc + 1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL reset_out out_valid=%b out=%h required 0/0", out_valid, out);
        end
        checks++;
        if ({zero, jump_address, regaddr_o, data_b_o} !== '0 ||
            {is_jump_o, branch_eq_o, branch_ne_o, wbi_o, M_o} !== '0) begin
            errors++;
            $display("FAIL reset_fields zero=%b jaddr=%h rd=%h db=%h required all 0", zero, jump_address, regaddr_o, data_b_o);
        end
        checks++;
        if (md_busy !== 1'b0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy md_busy=%b stall_out=%b required 0/0", md_busy, stall_out);
        end
        #2 reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_alu();
        int            acc, prev_acc;
        logic [4:0]    op;
        logic [DW-1:0] a, b, imm;
        logic          ui;
        send(5'd0, 32'h7FFFFFFF, 32'h12345678, 32'h1, 1'b1, 1'b1, 32'h80000000, acc);
        checks++;
        if (out_valid !== 1'b1 || out !== 32'h80000000 || zero !== 1'b0) begin
            errors++;
            $display("FAIL add_latency valid=%b out=%h zero=%b required 1/80000000/0", out_valid, out, zero);
        end
        checks++;
        if (jump_address !== npc + 32'h1) begin
            errors++;
            $display("FAIL jump_address got=%h required=%h", jump_address, npc + 32'h1);
        end
        send(5'd1, 32'd5, 32'd5, 32'h40, 1'b0, 1'b1, 32'h0, acc);
        checks++;
        if (zero !== 1'b1 || out !== 32'h0) begin
            errors++;
            $display("FAIL sub_zero zero=%b out=%h required 1/0", zero, out);
        end
        send(5'd6, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 32'h1, acc);
        send(5'd7, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 32'h0, acc);
        send(5'd10, 32'h80000000, 32'd31, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, acc);
        send(5'd9, 32'h80000000, 32'd31, 32'h0, 1'b0, 1'b1, 32'h1, acc);
        send(5'd8, 32'h1, 32'h20, 32'h0, 1'b0, 1'b1, 32'h1, acc);
        send(5'd5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, acc);
        send(5'd13, 32'd5, 32'd5, 32'h0, 1'b0, 1'b1, 32'h0, acc);
        prev_acc = acc;
        for (int i = 0; i < 16; i++) begin
            op  = 5'(i % 11);
            a   = $urandom;
            b   = $urandom;
            imm = $urandom;
            ui  = 1'(i % 3 == 0);
            send(op, a, b, imm, ui, 1'b1, alu_model(op, a, ui ? imm : b), acc);
            if (i == 15) begin
                checks++;
                if (acc - prev_acc !== 16) begin
                    errors++;
                    $display("FAIL back_to_back edges=%0d required=16", acc - prev_acc);
                end
            end
        end
    endtask

    task automatic test_muldiv();
        int            m, a, f;
        logic [DW-1:0] eh, el, x, y;
        send(5'd16, -32'sd3, 32'd7, 32'h0, 1'b0, 1'b0, 32'h0, m);
        send(5'd0, 32'd100, 32'd23, 32'h0, 1'b0, 1'b1, 32'd123, a);
        checks++;
        if (a !== m + 1) begin
            errors++;
            $display("FAIL add_during_mult accepted_edge=%0d required=%0d", a, m + 1);
        end
        send(5'd21, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFEB, f);
        checks++;
        if (f - m !== DW + 2) begin
            errors++;
            $display("FAIL mflo_stall edges_after_mult=%0d required=%0d", f - m, DW + 2);
        end
        send(5'd20, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, f);
        send(5'd18, -32'sd7, 32'd2, 32'h0, 1'b0, 1'b0, 32'h0, m);
        send(5'd21, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFD, f);
        send(5'd20, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, f);
        send(5'd19, 32'd7, 32'd0, 32'h0, 1'b0, 1'b0, 32'h0, m);
        send(5'd21, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, f);
        send(5'd20, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd7, f);
        send(5'd18, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 32'h0, m);
        send(5'd21, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80000000, f);
        send(5'd20, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, f);
        send(5'd18, -32'sd5, 32'd0, 32'h0, 1'b0, 1'b0, 32'h0, m);
        send(5'd21, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, f);
        send(5'd20, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFB, f);
        for (int i = 0; i < 8; i++) begin
            x = $urandom;
            y = (i == 3) ? 32'h1 : 32'($urandom);
            md_model(5'(16 + i % 4), x, y, eh, el);
            send(5'(16 + i % 4), x, y, 32'h0, 1'b0, 1'b0, 32'h0, m);
            send(5'd21, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, el, f);
            send(5'd20, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, eh, f);
        end
    endtask

    task automatic test_stall_flush();
        int            acc;
        exp_t          e;
        logic [DW-1:0] prev_out, eh, el, x, y;
        logic          prev_v;
        send(5'd0, 32'd1, 32'd2, 32'h0, 1'b0, 1'b1, 32'd3, acc);
        prev_out = out;
        prev_v   = out_valid;
        drive_fields(5'd4, 32'h0000F0F0, 32'h00000FF0, 32'h8, 1'b0, e);
        e.out  = 32'h0000FF00;
        e.zero = 1'b0;
        sb.push_back(e);
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            #1;
            checks++;
            if (stall_out !== 1'b1) begin
                errors++;
                $display("FAIL stall_out_hold cycle=%0d got=%b required=1", i, stall_out);
            end
            @(negedge clock);
            checks++;
            if (out !== prev_out || out_valid !== prev_v) begin
                errors++;
                $display("FAIL stall_frozen cycle=%0d out=%h valid=%b required %h/%b", i, out, out_valid, prev_out, prev_v);
            end
        end
        flush    = 1'b0;
        stall_in = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out !== 32'h0000FF00) begin
            errors++;
            $display("FAIL stall_release valid=%b out=%h required 1/0000ff00", out_valid, out);
        end
        in_valid = 1'b0;

        drive_fields(5'd0, 32'd4, 32'd4, 32'h0, 1'b0, e);
        flush = 1'b1;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_bubble out_valid=%b required=0", out_valid);
        end
        flush    = 1'b0;
        in_valid = 1'b0;

        x = 32'h00012345;
        y = -32'sd6789;
        md_model(5'd16, x, y, eh, el);
        send(5'd16, x, y, 32'h0, 1'b0, 1'b0, 32'h0, acc);
        for (int i = 0; i < 5; i++) begin
            drive_fields(5'd0, 32'(i), 32'(i), 32'h0, 1'b0, e);
            flush = 1'b1;
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_in_run cycle=%0d out_valid=%b required=0", i, out_valid);
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        send(5'd21, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, el, acc);
        send(5'd20, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, eh, acc);
    endtask

    task automatic test_reset_mid_div();
        int acc;
        send(5'd18, 32'd1000, 32'd7, 32'h0, 1'b0, 1'b0, 32'h0, acc);
        repeat (10) @(negedge clock);
        checks++;
        if (md_busy !== 1'b1) begin
            errors++;
            $display("FAIL div_running md_busy=%b required=1", md_busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (md_busy !== 1'b0 || out_valid !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL reset_mid_div busy=%b valid=%b out=%h required 0/0/0", md_busy, out_valid, out);
        end
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        send(5'd21, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, acc);
        checks++;
        if (md_busy !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mflo_after_reset busy=%b valid=%b required 0/1", md_busy, out_valid);
        end
        send(5'd20, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, acc);
    endtask

    task automatic test_dw16();
        int n;
        op16 = 5'd17;
        a16  = 16'hFFFF;
        b16  = 16'hFFFF;
        v16  = 1'b1;
        @(negedge clock);
        v16 = 1'b0;
        n = 0;
        while (busy16 === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        checks++;
        if (n !== DW16 + 1) begin
            errors++;
            $display("FAIL dw16_busy cycles=%0d required=%0d", n, DW16 + 1);
        end
        op16 = 5'd21;
        v16  = 1'b1;
        @(negedge clock);
        checks++;
        if (ov16 !== 1'b1 || o16 !== 16'h0001) begin
            errors++;
            $display("FAIL dw16_lo valid=%b out=%h required 1/0001", ov16, o16);
        end
        op16 = 5'd20;
        @(negedge clock);
        checks++;
        if (ov16 !== 1'b1 || o16 !== 16'hFFFE) begin
            errors++;
            $display("FAIL dw16_hi valid=%b out=%h required 1/fffe", ov16, o16);
        end
        v16 = 1'b0;
    endtask

    initial begin
        in_valid = 1'b0; flush = 1'b0; stall_in = 1'b0;
        data_a = '0; data_b = '0; data_imm = '0; npc = '0; alu_op = '0;
        use_imm = 1'b0; reg_dst = 1'b0; regaddr1 = '0; regaddr2 = '0;
        is_jump = 1'b0; branch_eq = 1'b0; branch_ne = 1'b0; wbi = '0; mem_ctl = 1'b0;
        v16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;

        test_reset();
        test_alu();
        test_muldiv();
        test_stall_flush();
        test_reset_mid_div();
        test_dw16();

        repeat (2) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_exe_md.md
Name: stage_exe_md

Overview:
- Parametrised next-generation MIPS execute stage: ALU, branch-target adder and EX/MEM pipeline register, plus an iterative multiply/divide unit with HI/LO registers.
- Sits between decode and memory stages.
- Adds pipeline stall/flush handshakes so multi-cycle MULT/DIV run alongside independent instructions.

Parameters:
- DW, 32, datapath width (even, >=8).
- RW, 5, register-address width.
- SHW, $clog2(DW), shift-amount width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  decode presents a valid instruction.
- flush  in  1  kill the instruction presented this cycle.
- stall_in  in  1  memory stage cannot accept; hold the output register.
- stall_out  out  1  decode must hold its instruction.
- data_a, data_b  in  DW  register operands.
- data_imm  in  DW  sign-extended immediate.
- npc  in  DW  next PC.
- alu_op  in  5  operation code (see Behaviour).
- use_imm  in  1  ALU B operand = data_imm, else data_b.
- reg_dst  in  1  destination select: 1 = regaddr1, 0 = regaddr2.
- regaddr1, regaddr2  in  RW  candidate destinations.
- is_jump, branch_eq, branch_ne  in  1  control passed to the IF stage.
- wbi  in  2  write-back control.
- mem_ctl  in  1  memory control.
- out_valid  out  1  output register holds a real instruction.
- out  out  DW  result.
- zero  out  1  result == 0.
- jump_address  out  DW  npc + data_imm.
- is_jump_o, branch_eq_o, branch_ne_o  out  1  registered control.
- wbi_o  out  2  registered write-back control.
- M_o  out  1  registered memory control.
- regaddr_o  out  RW  selected destination.
- data_b_o  out  DW  store data.
- md_busy  out  1  mult/div in progress.

Behaviour:
- Reset (async): every output register, HI, LO and the FSM counter go to 0; FSM enters IDLE. Applies immediately, including mid-operation; an in-flight mult/div is discarded.

Opcodes (alu_op):
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR: wrap modulo 2^DW.
- 6 SLT (signed), 7 SLTU: result is 1 or 0.
- 8 SLL, 9 SRL, 10 SRA: shift A by B[SHW-1:0].
- 16 MULT, 17 MULTU, 18 DIV, 19 DIVU.
- 20 MFHI, 21 MFLO.
- Any other code: result 0.

Acceptance:
- Accept = in_valid & !stall_out & !flush.
- stall_out = stall_in | (md_busy & alu_op in 16..21).
- Unrelated instructions proceed while md_busy.

Output register:
- Loads on every edge where stall_in = 0; holds everything while stall_in = 1.
- out_valid = accept, excluding opcodes 16..19. MULT/DIV issue a bubble (out_valid = 0) and write no register.
- On load, all registered fields latch the current-cycle values: out, zero, jump_address, controls, regaddr_o, data_b_o = data_b.
- Latency: 1 cycle for all non-mult/div ops.

Mult/div FSM, states IDLE -> RUN -> DONE -> IDLE:
- IDLE: an accepted opcode 16..19 latches operands (|A|,|B| and result signs for the signed forms), sets count = DW, goes RUN, and md_busy = 1 from the next cycle.
- RUN: one shift-add (mult) or restoring-subtract (div) step per cycle; count decrements. At count = 1, go DONE.
- DONE: apply sign fix-up; write {HI,LO} (mult) or LO = quotient, HI = remainder (div); return to IDLE. md_busy drops on the following edge.
- Total: DW+1 cycles from acceptance until HI/LO are valid.
- Signed divide: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- Divide by zero: LO = all ones, HI = dividend, no exception.
- Signed overflow (most-negative / -1, DIV only): LO = most-negative, HI = 0.
- MFHI/MFLO issued while idle read the current HI/LO combinationally.
- flush does not abort a running mult/div (it is older than the flushed instruction).

Simultaneous events:
- flush with stall_in = 1: the held output is unchanged.
- flush with stall_in = 0: a bubble loads.
- stall_in while the FSM is in DONE: HI/LO are still written (they are not part of the output register).

Test Plan:
- Reset mid-DIV (cycle 10 of RUN), then MFLO -> out = 0, out_valid = 1, md_busy = 0.
- ADD 0x7FFFFFFF + 1 with use_imm = 1, imm = 1 -> out = 0x80000000, zero = 0, 1-cycle latency; SUB 5 - 5 -> zero = 1; jump_address = npc + imm.
- MULT -3 x 7, then ADD, then MFLO -> ADD completes unstalled; MFLO stalls (stall_out = 1) until DW+1 cycles after MULT, then out = 0xFFFFFFEB. MFHI then gives 0xFFFFFFFF.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 0 -> LO = 0xFFFFFFFF, HI = 7.
- stall_in high for 3 cycles with a new instruction presented -> outputs frozen, stall_out = 1; the instruction loads on the first cycle stall_in = 0.
- flush with in_valid and ADD -> out_valid = 0 next cycle. flush during MULT RUN -> HI/LO are still written correctly.
- DW = 16 instance: MULTU 0xFFFF x 0xFFFF -> HI = 0xFFFE, LO = 0x0001 after 17 cycles.
